// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// riscv_ctrl_pkg : shared encodings for the RV32I control units
// Rev 1.0
// ============================================================================
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_JAL      = 4'd9,
        S_ALUWB    = 4'd10,
        S_BEQ      = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_supported_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) ||
               (op == OP_I) || (op == OP_JAL) || (op == OP_BRANCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_main_fsm_if.sv
`default_nettype none
// ============================================================================
// multicycle_main_fsm_if : controller <-> datapath strobe/select bundle
// Rev 1.0
// ============================================================================
interface multicycle_main_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal_instr;
    logic       instr_done;

    // master = control FSM, slave = datapath/memory side
    modport master (
        input  op, funct3, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               illegal_instr, instr_done
    );

    modport slave (
        output op, funct3, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               illegal_instr, instr_done
    );
endinterface
`default_nettype wire

// File: rtl/imm_src_decoder.sv
`default_nettype none
// ============================================================================
// imm_src_decoder : opcode -> immediate-format select, shared by control units
// Rev 1.0
// ============================================================================
module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] imm_src_o
);

    always_comb begin
        imm_src_o = IMM_I;
        case (op_i)
            OP_STORE:  imm_src_o = IMM_S;
            OP_BRANCH: imm_src_o = IMM_B;
            OP_JAL:    imm_src_o = IMM_J;
            default:   imm_src_o = IMM_I;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// multicycle_main_fsm : main control FSM of the multicycle RV32I datapath
// Rev 1.0
// ============================================================================
module multicycle_main_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    multicycle_main_fsm_if.master       ctrl
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    state_d = ctrl.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctrl.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (ctrl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = ctrl.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = ctrl.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXEC_R:   state_d = S_ALUWB;
            S_EXEC_I:   state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_RESET;
        endcase
    end

    // Moore decode; mem_ready and zero only qualify the handshake/branch strobes
    always_comb begin
        ctrl.pc_write      = 1'b0;
        ctrl.adr_src       = 1'b0;
        ctrl.mem_write     = 1'b0;
        ctrl.ir_write      = 1'b0;
        ctrl.reg_write     = 1'b0;
        ctrl.result_src    = RES_ALUOUT;
        ctrl.alu_src_a     = SRCA_PC;
        ctrl.alu_src_b     = SRCB_RS2;
        ctrl.alu_op        = ALUOP_ADD;
        ctrl.illegal_instr = 1'b0;
        ctrl.instr_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = ctrl.mem_ready;
                ctrl.pc_write   = ctrl.mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a     = SRCA_OLDPC;
                ctrl.alu_src_b     = SRCB_IMM;
                ctrl.illegal_instr = ~is_supported_op(ctrl.op);
                ctrl.instr_done    = ~is_supported_op(ctrl.op);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_RDATA;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = ctrl.mem_ready;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_ARITH;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ARITH;
            end
            S_JAL: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = 1'b1;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_BRANCH;
                ctrl.pc_write   = ctrl.zero;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    imm_src_decoder u_imm_src_decoder (
        .op_i      (ctrl.op),
        .imm_src_o (ctrl.imm_src)
    );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_multicycle_main_fsm : per-cycle output check against an instruction-level model
// Rev 1.0
// ============================================================================
module tb_multicycle_main_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       illegal;
        logic       done;
    } outs_t;

    typedef enum {P_RESET, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB,
                  P_MEMWRITE, P_EXR, P_EXI, P_JAL, P_ALUWB, P_BEQ} phase_e;

    typedef struct {
        logic [6:0] op;
        logic       zero;
        int         stall_fetch;
        int         stall_mem;
        int         exp_cycles;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_main_fsm_if bus ();

    multicycle_main_fsm dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    outs_t act;
    assign act = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                  bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src,
                  bus.illegal_instr, bus.instr_done};

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1101111, 7'b1100011};
    endfunction

    // Instruction latency with mem_ready held high
    function automatic int latency_of(input logic [6:0] op);
        case (op)
            7'b0000011: return 5;
            7'b0100011: return 4;
            7'b0110011, 7'b0010011, 7'b1101111: return 4;
            7'b1100011: return 3;
            default:    return 2;
        endcase
    endfunction

    function automatic outs_t expect_out(input phase_e p, input logic [6:0] op,
                                         input logic zero, input logic rdy);
        outs_t o;
        o = '0;
        o.imm_src = imm_of(op);
        case (p)
            P_RESET:    o = '0;
            P_FETCH:    begin o.result_src = 2'b10; o.alu_src_b = 2'b10;
                              o.ir_write = rdy; o.pc_write = rdy; end
            P_DECODE:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01;
                              o.illegal = !legal(op); o.done = !legal(op); end
            P_MEMADR:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
            P_MEMREAD:  o.adr_src = 1'b1;
            P_MEMWB:    begin o.result_src = 2'b01; o.reg_write = 1'b1; o.done = 1'b1; end
            P_MEMWRITE: begin o.adr_src = 1'b1; o.mem_write = 1'b1; o.done = rdy; end
            P_EXR:      begin o.alu_src_a = 2'b10; o.alu_op = 2'b10; end
            P_EXI:      begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_op = 2'b10; end
            P_JAL:      begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1; end
            P_ALUWB:    begin o.reg_write = 1'b1; o.done = 1'b1; end
            P_BEQ:      begin o.alu_src_a = 2'b10; o.alu_op = 2'b01;
                              o.pc_write = zero; o.done = 1'b1; end
            default:    o = '0;
        endcase
        return o;
    endfunction

    task automatic check_outs(input string tag, input phase_e p, input outs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s phase=%s: got %05h expected %05h", tag, p.name(), act, exp);
        end
    endtask

    task automatic step(input phase_e p, input logic [6:0] op, input logic zero,
                        input logic rdy, input string tag, output logic done_seen);
        bus.op        = op;
        bus.zero      = zero;
        bus.mem_ready = rdy;
        bus.funct3    = 3'($urandom);
        @(negedge clk);
        check_outs(tag, p, expect_out(p, op, zero, rdy));
        done_seen = act.done;
        @(posedge clk);
        #1;
    endtask

    // Expected phase sequence follows from the instruction class alone
    task automatic run_instr(input logic [6:0] op, input logic zero, input int sf,
                             input int sm, input int exp_cycles, input string tag);
        phase_e seq[$];
        int     cyc = 0;
        int     ndone = 0;
        int     first = -1;
        logic   d;
        seq = {P_FETCH, P_DECODE};
        case (op)
            7'b0000011: seq = {seq, P_MEMADR, P_MEMREAD, P_MEMWB};
            7'b0100011: seq = {seq, P_MEMADR, P_MEMWRITE};
            7'b0110011: seq = {seq, P_EXR, P_ALUWB};
            7'b0010011: seq = {seq, P_EXI, P_ALUWB};
            7'b1101111: seq = {seq, P_JAL, P_ALUWB};
            7'b1100011: seq = {seq, P_BEQ};
            default: ;
        endcase
        foreach (seq[i]) begin
            if (seq[i] inside {P_FETCH, P_MEMREAD, P_MEMWRITE}) begin
                for (int k = 0; k < ((seq[i] == P_FETCH) ? sf : sm); k++) begin
                    step(seq[i], op, zero, 1'b0, tag, d);
                    cyc++;
                    if (d) begin ndone++; if (first < 0) first = cyc; end
                end
                step(seq[i], op, zero, 1'b1, tag, d);
            end else begin
                step(seq[i], op, zero, 1'($urandom), tag, d);
            end
            cyc++;
            if (d) begin ndone++; if (first < 0) first = cyc; end
        end
        n_tests++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d expected 1", tag, ndone);
        end
        n_tests++;
        if (first != exp_cycles) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", tag, first, exp_cycles);
        end
    endtask

    vec_t vecs[12];

    initial begin
        logic       d;
        logic [6:0] rop;
        logic [6:0] legal_ops[6];
        int         sf, sm;

        vecs[0]  = '{7'b0000011, 1'b0, 0, 0, 5, "lw"};
        vecs[1]  = '{7'b0110011, 1'b0, 0, 0, 4, "add"};
        vecs[2]  = '{7'b0010011, 1'b1, 0, 0, 4, "addi"};
        vecs[3]  = '{7'b1101111, 1'b0, 0, 0, 4, "jal"};
        vecs[4]  = '{7'b1100011, 1'b1, 0, 0, 3, "beq_taken"};
        vecs[5]  = '{7'b1100011, 1'b0, 0, 0, 3, "beq_not_taken"};
        vecs[6]  = '{7'b0100011, 1'b0, 0, 0, 4, "sw"};
        vecs[7]  = '{7'b0000000, 1'b0, 0, 0, 2, "illegal_00"};
        vecs[8]  = '{7'b1111111, 1'b1, 0, 0, 2, "illegal_7f"};
        vecs[9]  = '{7'b0110011, 1'b0, 3, 0, 7, "fetch_stall3"};
        vecs[10] = '{7'b0100011, 1'b0, 0, 2, 6, "memwrite_stall2"};
        vecs[11] = '{7'b0000011, 1'b1, 1, 2, 8, "lw_stalls"};

        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                      7'b1101111, 7'b1100011};

        reset         = 1'b1;
        bus.op        = 7'b0000000;
        bus.funct3    = 3'b000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_hold", P_RESET, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs("reset_release", P_RESET, '0);
        @(posedge clk);
        #1;

        foreach (vecs[i])
            run_instr(vecs[i].op, vecs[i].zero, vecs[i].stall_fetch,
                      vecs[i].stall_mem, vecs[i].exp_cycles, vecs[i].name);

        // Asynchronous reset while a store is stalled in MEMWRITE
        step(P_FETCH,  7'b0100011, 1'b0, 1'b1, "rst_mid_sw", d);
        step(P_DECODE, 7'b0100011, 1'b0, 1'b1, "rst_mid_sw", d);
        step(P_MEMADR, 7'b0100011, 1'b0, 1'b1, "rst_mid_sw", d);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check_outs("rst_mid_sw_pre", P_MEMWRITE, expect_out(P_MEMWRITE, 7'b0100011, 1'b0, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ((act & ~outs_t'(17'h0000C)) !== '0) begin
            n_fail++;
            $display("FAIL rst_async_clear: got %05h expected 00000 (imm_src ignored)", act);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.op = 7'b0000000;
        #1;
        check_outs("rst_mid_sw_release", P_RESET, '0);
        @(posedge clk);
        #1;
        run_instr(7'b0110011, 1'b0, 0, 0, 4, "post_reset_add");

        // Randomised instruction stream
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0) rop = 7'($urandom);
            else                           rop = legal_ops[$urandom_range(0, 5)];
            sf = $urandom_range(0, 3);
            sm = $urandom_range(0, 3);
            run_instr(rop, 1'($urandom), sf, sm,
                      latency_of(rop) + sf + ((rop inside {7'b0000011, 7'b0100011}) ? sm : 0),
                      $sformatf("rand%0d_op%07b", n, rop));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
